// File: rtl/spdif_pkg.sv
// Shared types for the S/PDIF receive path.
// The optional mono mix is enabled by the PAIRER_MONO_MIX_EN macro in stereo_sample_pairer.
package spdif_pkg;

  localparam int PAIR_SAMPLE_W = 20;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    WAIT_L,
    HAVE_L
  } pair_state_t;

  typedef struct packed {
    logic [PAIR_SAMPLE_W-1:0] left;
    logic [PAIR_SAMPLE_W-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/pair_queue2.sv
// Two-entry synchronous FIFO with push/pop, full/empty and a drop-on-full strobe.
module pair_queue2 #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside a pop.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/stereo_sample_pairer.sv
// Pairs left/right subframe samples into stereo words and queues them for the sample FIFO.
// Define PAIRER_MONO_MIX_EN to add the mono_dout signed-average output.
module stereo_sample_pairer
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W       = 20,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vin,
  input  logic [SAMPLE_W-1:0]   din,
  input  logic                  channel,
  output logic [2*SAMPLE_W-1:0] dout,
  output logic                  vout,
  input  logic                  rdy,
  output logic [CNT_W-1:0]      orphan_cnt,
  output logic [CNT_W-1:0]      overwrite_cnt,
  output logic [CNT_W-1:0]      drop_cnt
`ifdef PAIRER_MONO_MIX_EN
  ,
  output logic [SAMPLE_W-1:0]   mono_dout
`endif
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef PAIRER_MONO_MIX_EN
  localparam int ENTRY_W = 3 * SAMPLE_W;
`else
  localparam int ENTRY_W = 2 * SAMPLE_W;
`endif

  pair_state_t         state;
  pair_state_t         next_state;
  logic [SAMPLE_W-1:0] held_left;
  logic [TIMER_W-1:0]  timer;

  logic push;
  logic pop;
  logic load_left;
  logic timer_inc;
  logic orphan_inc;
  logic overwrite_inc;

  logic [ENTRY_W-1:0] q_din;
  logic [ENTRY_W-1:0] q_dout;
  logic               q_empty;
  logic               q_full;
  logic               q_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_L;
      held_left <= '0;
      timer     <= '0;
    end else begin
      state <= next_state;
      if (load_left) begin
        held_left <= din;
        timer     <= '0;
      end else if (timer_inc) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // An arriving sample always wins over the timeout check on the same cycle.
  always_comb begin
    next_state    = state;
    push          = 1'b0;
    load_left     = 1'b0;
    timer_inc     = 1'b0;
    orphan_inc    = 1'b0;
    overwrite_inc = 1'b0;
    unique case (state)
      WAIT_L: begin
        if (vin) begin
          if (channel == CH_LEFT) begin
            load_left  = 1'b1;
            next_state = HAVE_L;
          end else begin
            orphan_inc = 1'b1;
          end
        end
      end
      HAVE_L: begin
        if (vin) begin
          if (channel == CH_RIGHT) begin
            push       = 1'b1;
            next_state = WAIT_L;
          end else begin
            load_left     = 1'b1;
            overwrite_inc = 1'b1;
          end
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          orphan_inc = 1'b1;
          next_state = WAIT_L;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: next_state = WAIT_L;
    endcase
  end

`ifdef PAIRER_MONO_MIX_EN
  // One extra sign bit keeps the sum exact; dropping its LSB is the arithmetic shift.
  logic [SAMPLE_W:0] mix_sum;
  assign mix_sum = {held_left[SAMPLE_W-1], held_left} + {din[SAMPLE_W-1], din};
  assign q_din   = {held_left, din, mix_sum[SAMPLE_W:1]};
  assign mono_dout = q_dout[SAMPLE_W-1:0];
  assign dout      = q_dout[ENTRY_W-1:SAMPLE_W];
`else
  assign q_din = {held_left, din};
  assign dout  = q_dout;
`endif

  assign vout = !q_empty;
  assign pop  = vout && rdy;

  pair_queue2 #(
    .W(ENTRY_W)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (q_din),
    .pop  (pop),
    .dout (q_dout),
    .empty(q_empty),
    .full (q_full),
    .drop (q_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_cnt    <= '0;
      overwrite_cnt <= '0;
      drop_cnt      <= '0;
    end else begin
      if (orphan_inc && (orphan_cnt != '1)) orphan_cnt <= orphan_cnt + 1'b1;
      if (overwrite_inc && (overwrite_cnt != '1)) overwrite_cnt <= overwrite_cnt + 1'b1;
      if (q_drop && q_full && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stereo_sample_pairer.sv
// Self-checking bench for stereo_sample_pairer: vector table, corner sequences, random vs. reference model.
// Define PAIRER_MONO_MIX_EN on both bench and RTL to exercise mono_dout.
module tb_stereo_sample_pairer;
  import spdif_pkg::*;

  localparam int SW      = 20;
  localparam int TIMEOUT = 2048;
  localparam int CMAX    = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vin = 1'b0;
  logic [SW-1:0] din = '0;
  logic          channel = 1'b0;
  logic          rdy = 1'b0;
  logic [2*SW-1:0] dout;
  logic          vout;
  logic [7:0]    orphan_cnt, overwrite_cnt, drop_cnt;
`ifdef PAIRER_MONO_MIX_EN
  logic [SW-1:0] mono_dout;
`endif

  int tests = 0;
  int failures = 0;

  // Reference model state: pairing rules expressed over a queue of stereo words.
  bit            m_held;
  logic [SW-1:0] m_left;
  int            m_idle;
  logic [2*SW-1:0] mq[$];
  int            m_orphan, m_over, m_drop;

  stereo_sample_pairer #(.SAMPLE_W(SW), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vin(vin), .din(din), .channel(channel),
    .dout(dout), .vout(vout), .rdy(rdy),
    .orphan_cnt(orphan_cnt), .overwrite_cnt(overwrite_cnt), .drop_cnt(drop_cnt)
`ifdef PAIRER_MONO_MIX_EN
    , .mono_dout(mono_dout)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2*SW-1:0] mkPair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    stereo_pair_t p;
    p.left  = l;
    p.right = r;
    return p;
  endfunction

  function automatic int satInc(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic modelReset();
    m_held = 0; m_left = '0; m_idle = 0;
    mq.delete();
    m_orphan = 0; m_over = 0; m_drop = 0;
  endtask

  task automatic modelStep(input logic v, input logic c, input logic [SW-1:0] d, input logic r);
    bit pop;
    bit push;
    logic [2*SW-1:0] pair;
    pop  = (mq.size() != 0) && r;
    push = 0;
    pair = '0;
    if (m_held) begin
      if (v && c) begin
        push = 1; pair = mkPair(m_left, d); m_held = 0;
      end else if (v) begin
        m_left = d; m_idle = 0; m_over = satInc(m_over);
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_held = 0; m_orphan = satInc(m_orphan);
        end
      end
    end else if (v) begin
      if (!c) begin
        m_held = 1; m_left = d; m_idle = 0;
      end else begin
        m_orphan = satInc(m_orphan);
      end
    end
    if (push && mq.size() == 2 && !pop) begin
      m_drop = satInc(m_drop);
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pair);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic c, input logic [SW-1:0] d, input logic r);
    vin = v; channel = c; din = d; rdy = r;
    @(posedge clk);
    modelStep(v, c, d, r);
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1; vin = 1'b0; rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCounters(input string tag, input int eo, input int ew, input int ed);
    checkOutput({tag, " orphan_cnt"}, 64'(orphan_cnt), 64'(eo));
    checkOutput({tag, " overwrite_cnt"}, 64'(overwrite_cnt), 64'(ew));
    checkOutput({tag, " drop_cnt"}, 64'(drop_cnt), 64'(ed));
  endtask

  typedef struct {
    logic v; logic c; logic [SW-1:0] d; logic r;
    logic ev; logic [2*SW-1:0] ed; int eo; int ew; int edr;
  } vec_t;

  initial begin : main
    vec_t tbl[8];
    logic [2*SW-1:0] p0, p1, p2, p3;
    bit saw_vout;

    tbl[0] = '{1, 0, 20'h12345, 1, 0, '0, 0, 0, 0};
    tbl[1] = '{1, 1, 20'hABCDE, 1, 1, 40'h12345ABCDE, 0, 0, 0};
    tbl[2] = '{0, 0, 20'h0,     1, 0, '0, 0, 0, 0};
    tbl[3] = '{1, 1, 20'h11111, 1, 0, '0, 1, 0, 0};
    tbl[4] = '{1, 0, 20'h1,     1, 0, '0, 1, 0, 0};
    tbl[5] = '{1, 0, 20'h2,     1, 0, '0, 1, 1, 0};
    tbl[6] = '{1, 1, 20'h3,     1, 1, mkPair(20'h2, 20'h3), 1, 1, 0};
    tbl[7] = '{0, 0, 20'h0,     1, 0, '0, 1, 1, 0};

    repeat (2) @(negedge clk);
    resetDut();
    checkOutput("reset vout", 64'(vout), 64'd0);
    checkOutput("reset dout", 64'(dout), 64'd0);
    checkCounters("reset", 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].r);
      checkOutput($sformatf("vec%0d vout", i), 64'(vout), 64'(tbl[i].ev));
      if (tbl[i].ev) checkOutput($sformatf("vec%0d dout", i), 64'(dout), 64'(tbl[i].ed));
      checkCounters($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ew, tbl[i].edr);
    end

    // Held left times out, then the late right is an orphan.
    resetDut();
    saw_vout = 0;
    applyStimulus(1, 0, 20'h4, 1);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(0, 0, '0, 1);
      if (vout) saw_vout = 1;
    end
    applyStimulus(1, 1, 20'h5, 1);
    if (vout) saw_vout = 1;
    checkOutput("timeout no pair", 64'(saw_vout), 64'd0);
    checkCounters("timeout", 2, 0, 0);

    // A right well inside the timeout window still pairs.
    resetDut();
    applyStimulus(1, 0, 20'h7, 1);
    repeat (2000) applyStimulus(0, 0, '0, 1);
    applyStimulus(1, 1, 20'h9, 1);
    checkOutput("late pair vout", 64'(vout), 64'd1);
    checkOutput("late pair dout", 64'(dout), 64'(mkPair(20'h7, 20'h9)));
    checkCounters("late pair", 0, 0, 0);

    // Backpressure: third pair is dropped, head stays stable.
    resetDut();
    p0 = mkPair(20'hA0000, 20'hB0000);
    p1 = mkPair(20'hA1111, 20'hB1111);
    p2 = mkPair(20'hA2222, 20'hB2222);
    applyStimulus(1, 0, p0[2*SW-1:SW], 0);
    applyStimulus(1, 1, p0[SW-1:0], 0);
    checkOutput("bp first vout", 64'(vout), 64'd1);
    checkOutput("bp first dout", 64'(dout), 64'(p0));
    applyStimulus(1, 0, p1[2*SW-1:SW], 0);
    applyStimulus(1, 1, p1[SW-1:0], 0);
    applyStimulus(1, 0, p2[2*SW-1:SW], 0);
    applyStimulus(1, 1, p2[SW-1:0], 0);
    checkOutput("bp hold dout", 64'(dout), 64'(p0));
    checkCounters("bp full", 0, 0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("bp drain1 vout", 64'(vout), 64'd1);
    checkOutput("bp drain1 dout", 64'(dout), 64'(p1));
    applyStimulus(0, 0, '0, 1);
    checkOutput("bp drain2 vout", 64'(vout), 64'd0);

    // Push and pop on the same cycle while full.
    resetDut();
    p3 = mkPair(20'hC3333, 20'hD3333);
    applyStimulus(1, 0, p0[2*SW-1:SW], 0);
    applyStimulus(1, 1, p0[SW-1:0], 0);
    applyStimulus(1, 0, p1[2*SW-1:SW], 0);
    applyStimulus(1, 1, p1[SW-1:0], 0);
    applyStimulus(1, 0, p3[2*SW-1:SW], 0);
    applyStimulus(1, 1, p3[SW-1:0], 1);
    checkOutput("full pushpop dout", 64'(dout), 64'(p1));
    checkCounters("full pushpop", 0, 0, 0);
    applyStimulus(0, 0, '0, 1);
    checkOutput("full pushpop next", 64'(dout), 64'(p3));
    applyStimulus(0, 0, '0, 1);
    checkOutput("full pushpop empty", 64'(vout), 64'd0);

    // Saturation, then reset with a pair queued.
    resetDut();
    repeat (300) applyStimulus(1, 1, 20'h00F0F, 1);
    checkCounters("saturate", 255, 0, 0);
    applyStimulus(1, 0, 20'h1, 0);
    applyStimulus(1, 1, 20'h2, 0);
    checkOutput("pre-reset vout", 64'(vout), 64'd1);
    resetDut();
    checkOutput("mid reset vout", 64'(vout), 64'd0);
    checkCounters("mid reset", 0, 0, 0);

`ifdef PAIRER_MONO_MIX_EN
    resetDut();
    applyStimulus(1, 0, 20'h7FFFF, 1);
    applyStimulus(1, 1, 20'h7FFFF, 1);
    checkOutput("mono max", 64'(mono_dout), 64'h7FFFF);
    applyStimulus(1, 0, 20'h80000, 1);
    applyStimulus(1, 1, 20'h00000, 1);
    checkOutput("mono neg", 64'(mono_dout), 64'hC0000);
`endif

    // Randomized traffic against the reference model.
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(9) < 6), 1'($urandom), SW'($urandom), ($urandom_range(1) == 1));
      checkOutput("rand vout", 64'(vout), 64'(mq.size() != 0));
      if (mq.size() != 0) checkOutput("rand dout", 64'(dout), 64'(mq[0]));
      checkCounters("rand", m_orphan, m_over, m_drop);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
